// File: rtl/instr_fetch_sequencer_if.sv
// Instruction memory bus between the fetch sequencer (master) and memory (slave).
// Read data is returned the cycle after a request is accepted (mem_waitrequest low).
interface instr_fetch_sequencer_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  modport master (
    output mem_address,
    output mem_read,
    input  mem_waitrequest,
    input  mem_readdata
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    output mem_waitrequest,
    output mem_readdata
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// FETCH/EXEC1/EXEC2 phase sequencer with PC, branch delay slot and halt-on-zero; 3 cycles per instruction minimum.
// Backpressure: FETCH holds while mem_waitrequest is high, EXEC2 holds while data_stall is high.
module instr_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                           clk,
  input  logic                           reset,
  instr_fetch_sequencer_if.master        bus,
  input  logic                           data_stall,
  input  logic                           branch_taken,
  input  logic [31:0]                    branch_target,
  output logic                           fetch,
  output logic                           exec1,
  output logic                           exec2,
  output logic [31:0]                    current_instruction,
  output logic [31:0]                    pc,
  output logic                           active,
  output logic                           fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_HALTED
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pending_target;
  logic [31:0] pending_target_nxt;
  logic [31:0] instr_reg;
  logic [31:0] instr_reg_nxt;
  logic        delay_pending;
  logic        delay_pending_nxt;
  logic        fault_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      pc             <= RESET_VECTOR;
      pending_target <= 32'd0;
      instr_reg      <= 32'd0;
      delay_pending  <= 1'b0;
      fault          <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      pending_target <= pending_target_nxt;
      instr_reg      <= instr_reg_nxt;
      delay_pending  <= delay_pending_nxt;
      fault          <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    pc_nxt              = pc;
    pending_target_nxt  = pending_target;
    instr_reg_nxt       = instr_reg;
    delay_pending_nxt   = delay_pending;
    fault_nxt           = fault;
    fetch               = 1'b0;
    exec1               = 1'b0;
    exec2               = 1'b0;
    active              = 1'b0;
    bus.mem_read        = 1'b0;
    current_instruction = instr_reg;

    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        fetch        = 1'b1;
        active       = 1'b1;
        bus.mem_read = 1'b1;
        if (!bus.mem_waitrequest) begin
          state_nxt = S_EXEC1;
        end
      end
      S_EXEC1: begin
        exec1               = 1'b1;
        active              = 1'b1;
        current_instruction = bus.mem_readdata;
        instr_reg_nxt       = bus.mem_readdata;
        state_nxt           = S_EXEC2;
      end
      S_EXEC2: begin
        exec2  = 1'b1;
        active = 1'b1;
        if (!data_stall) begin
          if (delay_pending) begin
            // Delay-slot instruction retiring: redirect now; a branch here is not allowed and is dropped.
            pc_nxt            = pending_target;
            delay_pending_nxt = 1'b0;
            if (pending_target == 32'd0) begin
              state_nxt = S_HALTED;
            end else if (pending_target[1:0] != 2'b00) begin
              state_nxt = S_HALTED;
              fault_nxt = 1'b1;
            end else begin
              state_nxt = S_FETCH;
            end
          end else if (branch_taken) begin
            pending_target_nxt = branch_target;
            delay_pending_nxt  = 1'b1;
            pc_nxt             = pc + 32'd4;
            state_nxt          = S_FETCH;
          end else begin
            pc_nxt    = pc + 32'd4;
            state_nxt = S_FETCH;
          end
        end
      end
      S_HALTED: begin
        state_nxt = S_HALTED;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.mem_address = pc;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer; memory returns address ^ 32'h5A5A0000 one cycle after acceptance.
module tb_instr_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        data_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        fetch;
  logic        exec1;
  logic        exec2;
  logic [31:0] current_instruction;
  logic [31:0] pc;
  logic        active;
  logic        fault;

  int checks;
  int failures;

  instr_fetch_sequencer_if bus ();

  instr_fetch_sequencer #(
    .RESET_VECTOR(32'hBFC00000)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus),
    .data_stall          (data_stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .fetch               (fetch),
    .exec1               (exec1),
    .exec2               (exec2),
    .current_instruction (current_instruction),
    .pc                  (pc),
    .active              (active),
    .fault               (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_readdata <= 32'd0;
    end else if (bus.mem_read && !bus.mem_waitrequest) begin
      bus.mem_readdata <= bus.mem_address ^ 32'h5A5A0000;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    checks              = 0;
    failures            = 0;
    reset               = 1'b1;
    bus.mem_waitrequest = 1'b0;
    data_stall          = 1'b0;
    branch_taken        = 1'b0;
    branch_target       = 32'd0;

    // Reset state
    step(); step();
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_strobes", {fetch, exec1, exec2}, 3'b000);
    check("rst_active", active, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_instr", current_instruction, 32'd0);
    check("rst_pc", pc, 32'hBFC00000);
    reset = 1'b0;

    // Zero-wait-state instruction
    step();
    check("c1_fetch", {fetch, exec1, exec2}, 3'b100);
    check("c1_mem_read", bus.mem_read, 1'b1);
    check("c1_addr", bus.mem_address, 32'hBFC00000);
    check("c1_active", active, 1'b1);
    step();
    check("c2_exec1", {fetch, exec1, exec2}, 3'b010);
    check("c2_instr", current_instruction, 32'hE59A0000);
    check("c2_mem_read", bus.mem_read, 1'b0);
    step();
    check("c3_exec2", {fetch, exec1, exec2}, 3'b001);
    check("c3_instr", current_instruction, 32'hE59A0000);
    step();
    check("c4_fetch", fetch, 1'b1);
    check("c4_addr", bus.mem_address, 32'hBFC00004);
    bus.mem_waitrequest = 1'b1;

    // Waitrequest high for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_fetch", {fetch, exec1, exec2}, 3'b100);
      check("wait_addr", bus.mem_address, 32'hBFC00004);
      check("wait_mem_read", bus.mem_read, 1'b1);
      if (i == 2) bus.mem_waitrequest = 1'b0;
    end
    step();
    check("wait_exec1", exec1, 1'b1);
    check("wait_instr", current_instruction, 32'hE59A0004);
    step();
    check("wait_exec2", exec2, 1'b1);

    // Taken branch at 0xBFC00008 with delay slot
    step();
    check("br_fetch_addr", bus.mem_address, 32'hBFC00008);
    step();
    step();
    check("br_exec2", exec2, 1'b1);
    check("br_pc", pc, 32'hBFC00008);
    branch_taken  = 1'b1;
    branch_target = 32'hBFC00100;
    step();
    branch_taken  = 1'b0;
    check("ds_fetch", fetch, 1'b1);
    check("ds_addr", bus.mem_address, 32'hBFC0000C);
    step();
    check("ds_instr", current_instruction, 32'hE59A000C);
    step();
    check("ds_exec2", exec2, 1'b1);
    branch_taken  = 1'b1;
    branch_target = 32'h00000040;
    step();
    branch_taken  = 1'b0;
    check("tgt_fetch", fetch, 1'b1);
    check("tgt_addr", bus.mem_address, 32'hBFC00100);
    step();
    check("tgt_instr", current_instruction, 32'hE59A0100);

    // Stall with a branch pulse mid-stall, real branch to a misaligned target
    step();
    check("st_exec2_a", exec2, 1'b1);
    data_stall    = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'd0;
    step();
    check("st_exec2_b", exec2, 1'b1);
    branch_taken  = 1'b0;
    step();
    check("st_exec2_c", exec2, 1'b1);
    data_stall    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'hBFC00002;
    step();
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    check("st_ds_addr", bus.mem_address, 32'hBFC00104);
    check("st_ds_fetch", fetch, 1'b1);
    step();
    check("st_ds_instr", current_instruction, 32'hE59A0104);
    step();
    check("st_ds_exec2", exec2, 1'b1);
    step();
    check("flt_active", active, 1'b0);
    check("flt_fault", fault, 1'b1);
    check("flt_pc", pc, 32'hBFC00002);
    check("flt_strobes", {fetch, exec1, exec2, bus.mem_read}, 4'b0000);
    step();
    check("flt_hold_pc", pc, 32'hBFC00002);
    check("flt_hold_read", bus.mem_read, 1'b0);

    // Jump to zero halts after the delay slot
    reset = 1'b1;
    step();
    check("rst2_fault", fault, 1'b0);
    check("rst2_pc", pc, 32'hBFC00000);
    reset = 1'b0;
    step();
    check("z_fetch_addr", bus.mem_address, 32'hBFC00000);
    step();
    step();
    check("z_exec2", exec2, 1'b1);
    branch_taken  = 1'b1;
    branch_target = 32'd0;
    step();
    branch_taken  = 1'b0;
    check("z_ds_pc", pc, 32'hBFC00004);
    step();
    check("z_ds_instr", current_instruction, 32'hE59A0004);
    step();
    check("z_ds_exec2", exec2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("z_halt_active", active, 1'b0);
      check("z_halt_pc", pc, 32'd0);
      check("z_halt_fault", fault, 1'b0);
      check("z_halt_read", bus.mem_read, 1'b0);
    end

    // Async reset mid-FETCH while a redirect is pending
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    branch_taken  = 1'b1;
    branch_target = 32'hBFC00200;
    step();
    branch_taken  = 1'b0;
    check("ar_pre_addr", bus.mem_address, 32'hBFC00004);
    check("ar_pre_fetch", fetch, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("ar_mem_read", bus.mem_read, 1'b0);
    check("ar_active", active, 1'b0);
    check("ar_pc", pc, 32'hBFC00000);
    step();
    reset = 1'b0;
    step();
    check("ar_fetch0", bus.mem_address, 32'hBFC00000);
    step();
    step();
    check("ar_exec2", exec2, 1'b1);
    step();
    check("ar_fetch1", bus.mem_address, 32'hBFC00004);
    step();
    step();
    step();
    check("ar_fetch2", bus.mem_address, 32'hBFC00008);
    check("ar_fetch2_strobe", fetch, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Control sequencer that produces the `fetch` / `exec1` / `exec2` phase strobes and the `current_instruction` word consumed by the instruction decode stage.
- Owns the PC, issues instruction reads on the shared memory bus and tolerates bus wait states.
- Implements the MIPS branch delay slot and halts the CPU when control transfers to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- mem_address  output  32  bus address, driven with PC during FETCH
- mem_read  output  1  instruction read request
- mem_waitrequest  input  1  bus stall; request held while high
- mem_readdata  input  32  read data, valid the cycle after the request is accepted
- data_stall  input  1  execute stage needs EXEC2 extended (data access or multicycle op)
- branch_taken  input  1  sampled in the final EXEC2 cycle; the current instruction redirects control
- branch_target  input  32  redirect address, sampled with branch_taken
- fetch  output  1  high in FETCH
- exec1  output  1  high in EXEC1
- exec2  output  1  high in EXEC2
- current_instruction  output  32  instruction word for decode
- pc  output  32  address of the instruction in flight
- active  output  1  CPU running
- fault  output  1  halted on a misaligned target

Behaviour:
- Reset (asynchronous, any state, including mid-fetch and with a pending branch):
  - state=IDLE, pc=RESET_VECTOR, delay_pending=0, pending_target=0, instr_reg=0.
  - Outputs: mem_read=0, fetch=exec1=exec2=0, active=0, fault=0, current_instruction=0.
- States: IDLE, FETCH, EXEC1, EXEC2, HALTED.
- IDLE: one cycle after reset deasserts, go to FETCH. active=1 from FETCH onward.
- FETCH:
  - mem_read=1, mem_address=pc, fetch=1.
  - If mem_waitrequest=1, stay in FETCH with address and read held stable.
  - If mem_waitrequest=0, the request is accepted; go to EXEC1.
- EXEC1:
  - exec1=1, mem_read=0.
  - current_instruction=mem_readdata (combinational pass-through).
  - instr_reg<=mem_readdata at the end of the cycle.
  - Always exactly 1 cycle; go to EXEC2.
- EXEC2:
  - exec2=1, current_instruction=instr_reg.
  - If data_stall=1, stay in EXEC2. branch_taken is ignored during stall cycles.
  - When data_stall=0 (final cycle), next-PC logic applies:
    1. If delay_pending=1 (this is the delay-slot instruction):
       - next pc=pending_target; delay_pending<=0; branch_taken in this cycle is ignored (no branch in a delay slot).
       - If pending_target==0: go to HALTED.
       - If pending_target[1:0]!=0: go to HALTED with fault<=1.
       - Otherwise go to FETCH.
    2. Else if branch_taken=1: pending_target<=branch_target, delay_pending<=1, pc<=pc+4, go to FETCH.
    3. Else: pc<=pc+4 (modulo 2^32 wrap, no flag), go to FETCH.
- Minimum instruction latency: 3 cycles (FETCH, EXEC1, EXEC2), plus one cycle per waitrequest or data_stall cycle.
- HALTED:
  - active=0, mem_read=0, all strobes 0.
  - pc holds the value that caused the halt (0 or the misaligned target).
  - Only reset exits this state.
- Outside EXEC1/EXEC2, current_instruction holds instr_reg.
- Only one of fetch/exec1/exec2 may be high in any cycle.
- mem_address=pc in all states.

Test Plan:
- Reset release, memory with zero wait states holding addiu at 0xBFC00000 -> mem_read high at 0xBFC00000 in cycle 1; exec1 with current_instruction=mem_readdata in cycle 2; exec2 in cycle 3; next fetch at 0xBFC00004 in cycle 4.
- Waitrequest held high for 3 cycles during a fetch -> FETCH lasts 4 cycles, mem_address and mem_read stable throughout, exec1 follows the first cycle with waitrequest low.
- branch_taken=1 with target 0xBFC00100 at pc 0xBFC00008 -> fetch 0xBFC0000C (delay slot), then fetch 0xBFC00100.
- Jump to target 0 (jr with zero register) -> delay-slot instruction at pc+4 executes fully, then active=0, pc=0, no further mem_read.
- data_stall high 2 cycles while branch_taken pulses during the stall -> exec2 lasts 3 cycles, branch honoured only if high in the final cycle; target 0xBFC00002 -> halt with fault=1 after the delay slot.
- Async reset asserted mid-FETCH with delay_pending=1 -> immediate mem_read=0 and active=0; after release, fetch resumes at 0xBFC00000 with no pending redirect.
